// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage data-memory access unit. Takes the memory/writeback control
// bundles produced in ID, runs loads and stores over a req/ack data-memory
// bus, and holds the pipeline while a bus transaction is outstanding.
// Stores get byte enables and lane-replicated data; loads get the addressed
// byte/halfword extracted and sign- or zero-extended. Misaligned or illegal
// accesses, and bus transactions that never see an ack, complete with fault.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   valid_in            : EX/MEM register holds a valid instruction
//   mem_ctrl            : MemRW (1 = store) and RWType (fun3 width encoding)
//   wb_ctrl             : MemtoReg == 2'd1 marks a load
//   addr_in, wdata_in   : byte address and store data
//   stall               : holds IF/ID/EX and the EX/MEM register
//   load_data           : extended load result, nonzero only with done && !fault
//   done, fault         : one-cycle completion strobe and its fault qualifier
//   dmem_req/we/addr/be/wdata : data-memory bus request side
//   dmem_ack, dmem_rdata      : data-memory bus response side
// ----------------------------------------------------------------------------
package mem_access_pkg;

    typedef struct packed {
        logic       MemRW;
        logic [2:0] RWType;
    } mem_control_t;

    typedef struct packed {
        logic [1:0] MemtoReg;
    } wb_control_t;

endpackage

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  mem_control_t mem_ctrl,
    input  wb_control_t  wb_ctrl,
    input  logic [31:0]  addr_in,
    input  logic [31:0]  wdata_in,
    output logic         stall,
    output logic [31:0]  load_data,
    output logic         done,
    output logic         fault,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [31:0]  dmem_addr,
    output logic [3:0]   dmem_be,
    output logic [31:0]  dmem_wdata,
    input  logic         dmem_ack,
    input  logic [31:0]  dmem_rdata
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic [31:0]       load_q, load_d;

    logic              is_mem;
    logic              start;
    logic              illegal;
    logic              misaligned;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       ext_load;
    logic              in_bus;

    // Request classification. start is masked by rst so that every output,
    // stall included, is zero while reset is held even if valid_in stays up.
    always_comb begin
        is_mem = mem_ctrl.MemRW || (wb_ctrl.MemtoReg == 2'd1);
        start  = valid_in && (state_q == IDLE) && is_mem && !rst;

        illegal = 1'b0;
        case (mem_ctrl.RWType)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = mem_ctrl.MemRW;
            default:                illegal = 1'b1;
        endcase

        misaligned = 1'b0;
        case (mem_ctrl.RWType[1:0])
            2'b01:   misaligned = addr_in[0];
            2'b10:   misaligned = (addr_in[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Store lane steering: narrow data is replicated across the word so the
    // byte enables alone select the target lanes. Loads always read a full word.
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = wdata_in;
        if (mem_ctrl.MemRW) begin
            case (mem_ctrl.RWType[1:0])
                2'b00: begin
                    req_be    = 4'b0001 << addr_in[1:0];
                    req_wdata = {4{wdata_in[7:0]}};
                end
                2'b01: begin
                    req_be    = 4'b0011 << addr_in[1:0];
                    req_wdata = {2{wdata_in[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = wdata_in;
                end
            endcase
        end
    end

    // Load extraction from the returned word, using the latched offset/op.
    always_comb begin
        case (off_q)
            2'd0:    sel_byte = dmem_rdata[7:0];
            2'd1:    sel_byte = dmem_rdata[15:8];
            2'd2:    sel_byte = dmem_rdata[23:16];
            default: sel_byte = dmem_rdata[31:24];
        endcase
        sel_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (op_q)
            3'b000:  ext_load = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  ext_load = {{16{sel_half[15]}}, sel_half};
            3'b100:  ext_load = {24'd0, sel_byte};
            3'b101:  ext_load = {16'd0, sel_half};
            default: ext_load = dmem_rdata;
        endcase
    end

    // Next-state logic. Bus fields are captured once on acceptance and held
    // for the whole BUS phase; DONE always falls back to IDLE so the same
    // instruction, still sitting in EX/MEM during DONE, cannot restart.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        load_d  = load_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    we_d    = mem_ctrl.MemRW;
                    addr_d  = {addr_in[31:2], 2'b00};
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    op_d    = mem_ctrl.RWType;
                    off_d   = addr_in[1:0];
                    cnt_d   = '0;
                    load_d  = 32'd0;
                    if (illegal || misaligned) begin
                        fault_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        fault_d = 1'b0;
                        state_d = BUS;
                    end
                end
            end

            BUS: begin
                if (dmem_ack) begin
                    fault_d = 1'b0;
                    load_d  = we_q ? 32'd0 : ext_load;
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    fault_d = 1'b1;
                    load_d  = 32'd0;
                    state_d = DONE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            op_q    <= 3'd0;
            off_q   <= 2'd0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            load_q  <= load_d;
        end
    end

    // Outputs decode from the state register, so bus fields are zero outside
    // BUS and the result is zero outside DONE.
    always_comb begin
        in_bus     = (state_q == BUS);
        stall      = start || in_bus;
        dmem_req   = in_bus;
        dmem_we    = in_bus && we_q;
        dmem_addr  = in_bus ? addr_q : 32'd0;
        dmem_be    = in_bus ? be_q : 4'd0;
        dmem_wdata = in_bus ? wdata_q : 32'd0;
        done       = (state_q == DONE);
        fault      = done && fault_q;
        load_data  = (done && !fault_q) ? load_q : 32'd0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed and randomized loads/stores against mem_access_unit built with a
// short timeout. Inputs are driven on the falling edge and outputs sampled
// 1 time unit later; expectations come from a byte-level reference model.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int unsigned TO = 4;

    logic         clk;
    logic         rst;
    logic         valid_in;
    mem_control_t mem_ctrl;
    wb_control_t  wb_ctrl;
    logic [31:0]  addr_in;
    logic [31:0]  wdata_in;
    logic         stall;
    logic [31:0]  load_data;
    logic         done;
    logic         fault;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [3:0]   dmem_be;
    logic [31:0]  dmem_wdata;
    logic         dmem_ack;
    logic [31:0]  dmem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .mem_ctrl   (mem_ctrl),
        .wb_ctrl    (wb_ctrl),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .stall      (stall),
        .load_data  (load_data),
        .done       (done),
        .fault      (fault),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit isLegal(input bit store, input logic [2:0] rw);
        if (rw == 3'd0 || rw == 3'd1 || rw == 3'd2) return 1'b1;
        if (!store && (rw == 3'd4 || rw == 3'd5)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int accessBytes(input logic [2:0] rw);
        if (rw[1:0] == 2'd0) return 1;
        if (rw[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] expBe(input bit store, input logic [2:0] rw,
                                          input logic [31:0] addr);
        int n;
        int mask;
        if (!store) return 32'hF;
        n = accessBytes(rw);
        mask = ((1 << n) - 1) << (addr % 4);
        return 32'(mask & 15);
    endfunction

    function automatic logic [31:0] expWdata(input logic [2:0] rw, input logic [31:0] data);
        int n;
        logic [31:0] res;
        n = accessBytes(rw);
        res = 32'd0;
        for (int i = 0; i < 4; i++) begin
            res = res | (((data >> (8 * (i % n))) & 32'hFF) << (8 * i));
        end
        return res;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] rw, input logic [31:0] addr,
                                            input logic [31:0] rdata);
        int n;
        logic [31:0] v;
        n = accessBytes(rw);
        v = rdata >> (8 * (addr % 4));
        if (n == 1) begin
            v = v & 32'hFF;
            if (rw == 3'd0 && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (n == 2) begin
            v = v & 32'hFFFF;
            if (rw == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    // One complete memory operation starting at the next falling edge.
    // ackDelay = 0 means the bus never answers.
    task automatic applyStimulus(input string name, input bit store, input logic [2:0] rw,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int ackDelay);
        bit expFault;
        int cyc;
        expFault = !isLegal(store, rw) || ((addr % accessBytes(rw)) != 0);

        @(negedge clk);
        valid_in         = 1'b1;
        mem_ctrl.MemRW   = store;
        mem_ctrl.RWType  = rw;
        wb_ctrl.MemtoReg = store ? 2'd0 : 2'd1;
        addr_in          = addr;
        wdata_in         = wdata;
        dmem_ack         = 1'b0;
        #1;
        checkOutput({name, " stall@accept"}, 32'(stall), 32'd1);
        checkOutput({name, " req@accept"}, 32'(dmem_req), 32'd0);

        if (expFault) begin
            @(negedge clk);
            #1;
            checkOutput({name, " done"}, 32'(done), 32'd1);
            checkOutput({name, " fault"}, 32'(fault), 32'd1);
            checkOutput({name, " stall@done"}, 32'(stall), 32'd0);
            checkOutput({name, " req@done"}, 32'(dmem_req), 32'd0);
            checkOutput({name, " load_data"}, load_data, 32'd0);
        end else if (ackDelay == 0) begin
            cyc = 0;
            while (cyc <= 40) begin
                @(negedge clk);
                cyc++;
                #1;
                if (done) break;
            end
            checkOutput({name, " timeout latency"}, 32'(cyc), 32'(TO + 1));
            checkOutput({name, " timeout fault"}, 32'(fault), 32'd1);
            checkOutput({name, " timeout req"}, 32'(dmem_req), 32'd0);
            checkOutput({name, " timeout load_data"}, load_data, 32'd0);
        end else begin
            for (int k = 1; k <= ackDelay; k++) begin
                @(negedge clk);
                if (k == ackDelay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                #1;
                checkOutput({name, " req"}, 32'(dmem_req), 32'd1);
                checkOutput({name, " we"}, 32'(dmem_we), 32'(store));
                checkOutput({name, " addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
                checkOutput({name, " be"}, 32'(dmem_be), expBe(store, rw, addr));
                if (store) checkOutput({name, " wdata"}, dmem_wdata, expWdata(rw, wdata));
                checkOutput({name, " stall@bus"}, 32'(stall), 32'd1);
                checkOutput({name, " done@bus"}, 32'(done), 32'd0);
            end
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            #1;
            checkOutput({name, " done"}, 32'(done), 32'd1);
            checkOutput({name, " fault"}, 32'(fault), 32'd0);
            checkOutput({name, " stall@done"}, 32'(stall), 32'd0);
            checkOutput({name, " req@done"}, 32'(dmem_req), 32'd0);
            checkOutput({name, " load_data"}, load_data, store ? 32'd0 : expLoad(rw, addr, rdata));
        end
    endtask

    task automatic goIdle();
        @(negedge clk);
        valid_in         = 1'b0;
        mem_ctrl         = '0;
        wb_ctrl          = '0;
        dmem_ack         = 1'b0;
        #1;
        checkOutput("idle stall", 32'(stall), 32'd0);
        checkOutput("idle done", 32'(done), 32'd0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " stall"}, 32'(stall), 32'd0);
        checkOutput({name, " done"}, 32'(done), 32'd0);
        checkOutput({name, " fault"}, 32'(fault), 32'd0);
        checkOutput({name, " req"}, 32'(dmem_req), 32'd0);
        checkOutput({name, " we"}, 32'(dmem_we), 32'd0);
        checkOutput({name, " be"}, 32'(dmem_be), 32'd0);
        checkOutput({name, " addr"}, dmem_addr, 32'd0);
        checkOutput({name, " wdata"}, dmem_wdata, 32'd0);
        checkOutput({name, " load_data"}, load_data, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        rst        = 1'b1;
        valid_in   = 1'b0;
        mem_ctrl   = '0;
        wb_ctrl    = '0;
        addr_in    = 32'd0;
        wdata_in   = 32'd0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;

        @(negedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        // Directed stores
        applyStimulus("SW", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2);
        applyStimulus("SB", 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
        applyStimulus("SH", 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 1);
        goIdle();

        // Directed loads from a fixed word
        rd = 32'h80FF7F01;
        applyStimulus("LB", 1'b0, 3'b000, 32'h102, 32'h0, rd, 1);
        applyStimulus("LBU", 1'b0, 3'b100, 32'h102, 32'h0, rd, 2);
        applyStimulus("LH", 1'b0, 3'b001, 32'h102, 32'h0, rd, 3);
        applyStimulus("LHU", 1'b0, 3'b101, 32'h100, 32'h0, rd, 1);
        applyStimulus("LW", 1'b0, 3'b010, 32'h104, 32'h0, rd, 1);
        goIdle();

        // Fault path
        applyStimulus("LW misaligned", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
        applyStimulus("SH misaligned", 1'b1, 3'b001, 32'h103, 32'h1234, 32'h0, 1);
        applyStimulus("RWType 011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1);
        applyStimulus("SBU illegal", 1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 1);
        goIdle();

        // Timeout, then a late ack while idle must be ignored
        applyStimulus("LW timeout", 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 0);
        @(negedge clk);
        valid_in   = 1'b0;
        mem_ctrl   = '0;
        wb_ctrl    = '0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        #1;
        checkOutput("late ack stall", 32'(stall), 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        checkOutput("late ack done", 32'(done), 32'd0);
        checkOutput("late ack req", 32'(dmem_req), 32'd0);

        // Randomized operations, sometimes back-to-back
        for (int i = 0; i < 30; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          $urandom, $urandom, $urandom, int'($urandom_range(1, 3)));
            if ($urandom_range(0, 2) == 0) goIdle();
        end
        goIdle();

        // Reset while in BUS, with the instruction still presented
        @(negedge clk);
        valid_in         = 1'b1;
        mem_ctrl.MemRW   = 1'b0;
        mem_ctrl.RWType  = 3'b010;
        wb_ctrl.MemtoReg = 2'd1;
        addr_in          = 32'h300;
        @(negedge clk);
        #1;
        checkOutput("pre-reset req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        checkAllZero("mid reset");
        @(negedge clk);
        #1;
        checkAllZero("held reset");
        valid_in = 1'b0;
        rst      = 1'b0;
        applyStimulus("LW after reset", 1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 2);
        goIdle();

        // Non-memory instruction: no stall, no activity
        @(negedge clk);
        valid_in         = 1'b1;
        mem_ctrl.MemRW   = 1'b0;
        mem_ctrl.RWType  = 3'b010;
        wb_ctrl.MemtoReg = 2'd0;
        #1;
        checkOutput("rtype stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rtype stall next", 32'(stall), 32'd0);
        checkOutput("rtype req", 32'(dmem_req), 32'd0);
        checkOutput("rtype done", 32'(done), 32'd0);
        valid_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
